// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: req/ack fetch into a small FIFO feeding decode.
// Optional perf counters are enabled with the IF_PERF_EN macro.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_branch_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_ce
`ifdef IF_PERF_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt
`endif
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_pc_q [IBUF_DEPTH];
  logic [31:0]   buf_pc_d [IBUF_DEPTH];
  logic [31:0]   buf_ins_q [IBUF_DEPTH];
  logic [31:0]   buf_ins_d [IBUF_DEPTH];
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   opc_q, opc_d;
  logic          ce_q, ce_d;
  logic          push;
  logic          pop;
  logic [1:0]    unused_bpc;

  assign unused_bpc  = i_branch_pc[1:0];
  assign o_imem_req  = rst_n && !i_flush && (cnt_q < DEPTH_C);
  assign o_imem_addr = pc_q;
  assign push        = o_imem_req && i_imem_ack;
  assign pop         = !i_flush && !i_stall && (cnt_q != '0);

  assign o_instr = instr_q;
  assign o_pc    = opc_q;
  assign o_ce    = ce_q;

  // Next-state: flush redirect, else pop to output and push fetched word.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    ce_d     = ce_q;
    for (int i = 0; i < IBUF_DEPTH; i++) begin
      buf_pc_d[i]  = buf_pc_q[i];
      buf_ins_d[i] = buf_ins_q[i];
    end
    if (i_flush) begin
      pc_d     = {i_branch_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      instr_d  = NOP;
      ce_d     = 1'b0;
    end else begin
      if (pop) begin
        instr_d  = buf_ins_q[rd_ptr_q];
        opc_d    = buf_pc_q[rd_ptr_q];
        ce_d     = 1'b1;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (!i_stall) begin
        ce_d = 1'b0;
      end
      if (push) begin
        buf_pc_d[wr_ptr_q]  = pc_q;
        buf_ins_d[wr_ptr_q] = i_imem_data;
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + 32'd4;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      instr_q  <= NOP;
      opc_q    <= '0;
      ce_q     <= 1'b0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        buf_pc_q[i]  <= '0;
        buf_ins_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      ce_q     <= ce_d;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        buf_pc_q[i]  <= buf_pc_d[i];
        buf_ins_q[i] <= buf_ins_d[i];
      end
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count accepted fetches and cycles where decode gets nothing.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + (push ? 32'd1 : 32'd0);
    bubble_cnt_d = bubble_cnt_q;
    if (!i_stall && !i_flush && cnt_q == '0) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule
